// File: rtl/parallel_serial_tx.sv
// Byte-parallel to bit-serial transmitter.
// Sends a startup comma train, then user bytes or idle commas, LSB first.
module parallel_serial_tx #(
  parameter int COMMA_COUNT = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] DATA_IN,
  input  logic       VALID_IN,
  output logic       IN_READY,
  output logic       DATA_OUT,
  output logic       DATA_FRAME,
  output logic       TX_SYNCED
);

  localparam logic [7:0] COMMA     = 8'hBC;
  localparam logic [3:0] SYNC_LAST = 4'(COMMA_COUNT);

  typedef enum logic {
    ST_SYNC,
    ST_RUN
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] frame_q, frame_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [3:0] sync_cnt_q, sync_cnt_d;
  logic       frame_type_q, frame_type_d;
  logic       data_out_q, data_out_d;
  logic       data_frame_q, data_frame_d;

  logic       accept;
  logic       boundary;
  logic       load_held;

  assign accept   = VALID_IN & ~hold_full_q;
  assign boundary = (bit_cnt_q == 3'd7);

  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    bit_cnt_d    = bit_cnt_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    sync_cnt_d   = sync_cnt_q;
    frame_type_d = frame_type_q;
    load_held    = 1'b0;
    data_out_d   = frame_q[bit_cnt_q];
    data_frame_d = frame_type_q;

    if (accept) begin
      hold_d      = DATA_IN;
      hold_full_d = 1'b1;
    end

    if (!boundary) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
    end else begin
      bit_cnt_d    = 3'd0;
      frame_d      = COMMA;
      frame_type_d = 1'b0;
      unique case (state_q)
        ST_SYNC: begin
          if (sync_cnt_q == SYNC_LAST) begin
            state_d   = ST_RUN;
            load_held = 1'b1;
          end else begin
            sync_cnt_d = sync_cnt_q + 4'd1;
          end
        end
        ST_RUN: load_held = 1'b1;
        default: state_d = ST_SYNC;
      endcase
      // accept cannot fire here when full, so clearing is safe
      if (load_held && hold_full_q) begin
        frame_d      = hold_q;
        frame_type_d = 1'b1;
        hold_full_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= ST_SYNC;
      frame_q      <= COMMA;
      bit_cnt_q    <= 3'd0;
      hold_q       <= 8'd0;
      hold_full_q  <= 1'b0;
      sync_cnt_q   <= 4'd1;
      frame_type_q <= 1'b0;
      data_out_q   <= 1'b0;
      data_frame_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      bit_cnt_q    <= bit_cnt_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      sync_cnt_q   <= sync_cnt_d;
      frame_type_q <= frame_type_d;
      data_out_q   <= data_out_d;
      data_frame_q <= data_frame_d;
    end
  end

  assign IN_READY   = ~hold_full_q;
  assign DATA_OUT   = data_out_q;
  assign DATA_FRAME = data_frame_q;
  assign TX_SYNCED  = (state_q == ST_RUN);

endmodule
